// File: rtl/des_sbox_scheduler.sv
// DES round S-box scheduler: one 48-bit key-mixed word in, eight sequential
// 6-bit lookups through a shared S-box bank, one 32-bit substitution word out.
module des_sbox_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic [2:0]  sbox_sel,
  output logic [5:0]  sbox_addr,
  output logic        sbox_en,
  input  logic [3:0]  sbox_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  idx;
  logic [47:0] buffer;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) is reserved for combinational blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)     state_next = LOOKUP;
      LOOKUP:  if (idx == 3'd7)  state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Handshake and bank-port outputs decode from the state register only, so
  // the asynchronous reset clears them immediately and no in_* to out_* path
  // exists.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    sbox_en   = (state == LOOKUP);
    sbox_sel  = 3'd0;
    sbox_addr = 6'd0;
    if (state == LOOKUP) begin
      sbox_sel = idx;
      for (int i = 0; i < 8; i++) begin
        if (idx == 3'(i)) sbox_addr = buffer[47-6*i -: 6];
      end
    end
  end

  // NOTE: the input buffer and result register are reset explicitly; a
  // reset must never let a stale or partial word become visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 3'd0;
      buffer   <= 48'd0;
      out_data <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            buffer   <= in_data;
            idx      <= 3'd0;
            out_data <= 32'd0;
          end
        end
        LOOKUP: begin
          for (int i = 0; i < 8; i++) begin
            if (idx == 3'(i)) out_data[31-4*i -: 4] <= sbox_data;
          end
          // idx parks at 7 in DONE and is cleared on the next acceptance.
          if (idx != 3'd7) idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_scheduler.sv
// Self-checking bench for des_sbox_scheduler: models the real DES S-box bank
// and predicts each result directly from the DES substitution definition.
module tb_des_sbox_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [2:0]  sbox_sel;
  logic [5:0]  sbox_addr;
  logic        sbox_en;
  logic [3:0]  sbox_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_sbox_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sbox_sel  (sbox_sel),
    .sbox_addr (sbox_addr),
    .sbox_en   (sbox_en),
    .sbox_data (sbox_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Standard DES tables: entry 4*s+row holds the 16 columns of S(s+1), MSB first.
  function automatic logic [63:0] sbox_row(input int n);
    case (n)
      0:  return 64'hE4D12FB83A6C5907;  1:  return 64'h0F74E2D1A6CB9538;
      2:  return 64'h41E8D62BFC973A50;  3:  return 64'hFC8249175B3EA06D;
      4:  return 64'hF18E6B34972DC05A;  5:  return 64'h3D47F28EC01A69B5;
      6:  return 64'h0E7BA4D158C6932F;  7:  return 64'hD8A13F42B67C05E9;
      8:  return 64'hA09E63F51DC7B428;  9:  return 64'hD70934A6285ECBF1;
      10: return 64'hD6498F30B12C5AE7;  11: return 64'h1AD069874FE3B52C;
      12: return 64'h7DE3069A1285BC4F;  13: return 64'hD8B56F03472C1AE9;
      14: return 64'hA690CB7DF13E5284;  15: return 64'h3F06A1D8945BC72E;
      16: return 64'h2C417AB6853FD0E9;  17: return 64'hEB2C47D150FA3986;
      18: return 64'h421BAD78F9C5630E;  19: return 64'hB8C71E2D6F09A453;
      20: return 64'hC1AF92680D34E75B;  21: return 64'hAF427C9561DE0B38;
      22: return 64'h9EF528C3704A1DB6;  23: return 64'h432C95FABE17608D;
      24: return 64'h4B2EF08D3C975A61;  25: return 64'hD0B7491AE35C2F86;
      26: return 64'h14BDC37EAF680592;  27: return 64'h6BD814A7950FE23C;
      28: return 64'hD2846FB1A93E50C7;  29: return 64'h1FD8A374C56B0E92;
      30: return 64'h7B419CE206ADF358;  31: return 64'h21E74A8DFC90356B;
      default: return 64'd0;
    endcase
  endfunction

  // Row = outer address bits (b6,b1), column = middle four bits.
  function automatic logic [3:0] sbox_lookup(input int s, input int a);
    int row, col;
    logic [63:0] r;
    row = ((a >> 4) & 2) | (a & 1);
    col = (a >> 1) & 15;
    r   = sbox_row(4 * s + row);
    return 4'((r >> (4 * (15 - col))) & 64'hF);
  endfunction

  function automatic int chunk(input logic [47:0] w, input int i);
    return int'((w >> (6 * (7 - i))) & 48'h3F);
  endfunction

  function automatic logic [31:0] des_subst(input logic [47:0] w);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 8; i++) r = (r << 4) | 32'(sbox_lookup(i, chunk(w, i)));
    return r;
  endfunction

  assign sbox_data = sbox_lookup(int'(sbox_sel), int'(sbox_addr));

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  48'(in_ready),  48'd1);
    check({tag, "_out_valid"}, 48'(out_valid), 48'd0);
    check({tag, "_out_data"},  48'(out_data),  48'd0);
    check({tag, "_sbox_en"},   48'(sbox_en),   48'd0);
    check({tag, "_sbox_sel"},  48'(sbox_sel),  48'd0);
    check({tag, "_sbox_addr"}, 48'(sbox_addr), 48'd0);
  endtask

  // Presents w and returns just after the accepting edge.
  task automatic accept(input logic [47:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
    check("in_ready_wait", 48'(in_ready), 48'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Follows the eight lookup cycles and the first DONE cycle.
  task automatic lookup_trace(input logic [47:0] w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("lk%0d_en", i),    48'(sbox_en),   48'd1);
      check($sformatf("lk%0d_sel", i),   48'(sbox_sel),  48'(i));
      check($sformatf("lk%0d_addr", i),  48'(sbox_addr), 48'(chunk(w, i)));
      check($sformatf("lk%0d_valid", i), 48'(out_valid), 48'd0);
    end
    @(negedge clk);
    check("done_valid",    48'(out_valid), 48'd1);
    check("done_en",       48'(sbox_en),   48'd0);
    check("done_in_ready", 48'(in_ready),  48'd0);
    check("done_data",     48'(out_data),  48'(des_subst(w)));
  endtask

  task automatic wait_out_valid();
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    check("out_valid_wait", 48'(out_valid), 48'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] w;
    time t0, t1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 48'd0;
    out_ready = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Constant expectations double as a check on the reference tables.
    check("model_zero", 48'(des_subst(48'h0)), 48'hEFA72C4D);
    check("model_ones", 48'(des_subst(48'hFFFFFFFFFFFF)), 48'hD9CE3DCB);

    // All-zero then all-ones words with out_ready already high.
    accept(48'h0);
    lookup_trace(48'h0);
    check("zero_data", 48'(out_data), 48'hEFA72C4D);
    @(negedge clk);
    check("zero_hs_valid", 48'(out_valid), 48'd0);
    check("zero_hs_ready", 48'(in_ready),  48'd1);

    accept(48'hFFFFFFFFFFFF);
    lookup_trace(48'hFFFFFFFFFFFF);
    check("ones_data", 48'(out_data), 48'hD9CE3DCB);
    @(negedge clk);
    check("ones_hs_ready", 48'(in_ready), 48'd1);

    // Backpressure: 20 held cycles with an ignored in_valid pulse.
    out_ready = 1'b0;
    w = {16'($urandom), $urandom};
    accept(w);
    lookup_trace(w);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 5) begin
        in_valid = 1'b1;
        in_data  = ~w;
      end
      if (c == 6) in_valid = 1'b0;
      check("bp_valid",    48'(out_valid), 48'd1);
      check("bp_data",     48'(out_data),  48'(des_subst(w)));
      check("bp_in_ready", 48'(in_ready),  48'd0);
      check("bp_en",       48'(sbox_en),   48'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", 48'(out_valid), 48'd0);
    check("bp_rel_ready", 48'(in_ready),  48'd1);
    @(negedge clk);
    check("bp_no_accept", 48'(sbox_en), 48'd0);

    // Back-to-back with in_valid and out_ready held high.
    in_valid = 1'b1;
    in_data  = 48'h0;
    check("b2b_ready0", 48'(in_ready), 48'd1);
    @(posedge clk);
    t0 = $time;
    #1 in_data = 48'hFFFFFFFFFFFF;
    wait_out_valid();
    check("b2b_first", 48'(out_data), 48'hEFA72C4D);
    for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
    check("b2b_ready1", 48'(in_ready), 48'd1);
    @(posedge clk);
    t1 = $time;
    #1 in_valid = 1'b0;
    check("b2b_interval", 48'((t1 - t0) / 10), 48'd10);
    wait_out_valid();
    check("b2b_second", 48'(out_data), 48'hD9CE3DCB);
    @(negedge clk);

    // Sequencing: every chunk is 6'h01.
    accept(48'h041041041041);
    lookup_trace(48'h041041041041);
    @(negedge clk);

    // Mid-operation reset at idx = 4.
    accept(48'h0);
    repeat (5) @(negedge clk);
    check("mid_sel_before", 48'(sbox_sel), 48'd4);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    accept(48'h0);
    lookup_trace(48'h0);
    check("post_reset_data", 48'(out_data), 48'hEFA72C4D);
    @(negedge clk);

    // Randomised words with random backpressure.
    for (int k = 0; k < 12; k++) begin
      out_ready = 1'b0;
      w = {16'($urandom), $urandom};
      accept(w);
      lookup_trace(w);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rnd_hold", 48'(out_data), 48'(des_subst(w)));
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("rnd_hs", 48'(out_valid), 48'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
